// File: rtl/multiplier_256bits_serdes_wrapper.sv
// Stream front/back end for a combinational 256x256 multiplier: collects A and B
// from 32-bit input words, waits a settle budget, then streams the 512-bit product out.
module multiplier_256bits_serdes_wrapper #(
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned OP_W       = 256,
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WORD_W-1:0]   in_data,
  output logic [OP_W-1:0]     mult_a,
  output logic [OP_W-1:0]     mult_b,
  input  logic [2*OP_W-1:0]   mult_product,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORD_W-1:0]   out_data,
  output logic                out_last,
  output logic                busy
);

  localparam int unsigned N_OP   = OP_W / WORD_W;
  localparam int unsigned N_PROD = 2 * N_OP;
  localparam int unsigned CNT_W  = $clog2(N_PROD);
  localparam int unsigned IDX_W  = $clog2(N_OP);

  localparam logic [CNT_W-1:0] OP_LAST     = CNT_W'(N_OP - 1);
  localparam logic [CNT_W-1:0] PROD_LAST   = CNT_W'(N_PROD - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    LOAD_A,
    LOAD_B,
    SETTLE,
    SEND
  } state_e;

  state_e                          state_q;
  logic [CNT_W-1:0]                cnt_q;
  logic [CNT_W-1:0]                cnt_inc;
  logic [N_OP-1:0][WORD_W-1:0]     a_q;
  logic [N_OP-1:0][WORD_W-1:0]     b_q;
  logic [N_PROD-1:0][WORD_W-1:0]   prod_q;
  logic                            out_valid_q;
  logic [WORD_W-1:0]               out_data_q;
  logic                            out_last_q;

  assign cnt_inc = cnt_q + CNT_W'(1);

  // NOTE: every register below is written with <= so all updates in one edge see
  // the pre-edge values; the wide operand/product words are reset as well so an
  // aborted load never leaves stale words on mult_a/mult_b.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD_A;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      prod_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      unique case (state_q)
        LOAD_A: begin
          if (in_valid) begin
            a_q[cnt_q[IDX_W-1:0]] <= in_data;
            if (cnt_q == OP_LAST) begin
              state_q <= LOAD_B;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
        end
        LOAD_B: begin
          if (in_valid) begin
            b_q[cnt_q[IDX_W-1:0]] <= in_data;
            if (cnt_q == OP_LAST) begin
              state_q <= SETTLE;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
        end
        // Operands are frozen here; the product is sampled once, on the last settle cycle.
        SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            prod_q  <= mult_product;
            state_q <= SEND;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        // First SEND cycle primes the output register from prod_q; afterwards
        // each accepted word advances to the next one.
        SEND: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            out_data_q  <= prod_q[cnt_q];
            out_last_q  <= (cnt_q == PROD_LAST);
          end else if (out_ready) begin
            if (out_last_q) begin
              state_q     <= LOAD_A;
              cnt_q       <= '0;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
            end else begin
              cnt_q      <= cnt_inc;
              out_data_q <= prod_q[cnt_inc];
              out_last_q <= (cnt_inc == PROD_LAST);
            end
          end
        end
        default: begin
          state_q <= LOAD_A;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == LOAD_A) || (state_q == LOAD_B);
  assign busy      = (state_q != LOAD_A) || (cnt_q != '0);
  assign mult_a    = a_q;
  assign mult_b    = b_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_multiplier_256bits_serdes_wrapper.sv
// Directed bench: a behavioural multiplier core closes the loop; expected product
// words are hand-computed constants.
module tb_multiplier_256bits_serdes_wrapper;

  localparam int SETTLE = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic [255:0] mult_a;
  logic [255:0] mult_b;
  logic [511:0] mult_product;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic         out_last;
  logic         busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign mult_product = {256'b0, mult_a} * {256'b0, mult_b};

  multiplier_256bits_serdes_wrapper #(
    .WORD_W    (32),
    .OP_W      (256),
    .SETTLE_CYC(SETTLE)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .mult_a      (mult_a),
    .mult_b      (mult_b),
    .mult_product(mult_product),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Presents one word and returns just after the edge that accepted it.
  task automatic send_word(input logic [31:0] d, input bit gaps);
    int guard = 0;
    if (gaps) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("in_ready_wait", guard < 100, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic load_op(input logic [255:0] a, input logic [255:0] b, input bit gaps,
                         input bit keep_valid, input logic [31:0] next_word);
    for (int i = 0; i < 16; i++)
      send_word((i < 8) ? a[i*32 +: 32] : b[(i-8)*32 +: 32], gaps);
    if (keep_valid) in_data = next_word;
    else            in_valid = 1'b0;
  endtask

  // Called right after the last B word; counts edges until out_valid rises.
  task automatic wait_valid(input logic [255:0] a, input logic [255:0] b);
    int n = 0;
    while (!out_valid && n < 50) begin
      check("settle_in_ready", in_ready, 1'b0);
      check("settle_busy", busy, 1'b1);
      check("settle_hold_a", mult_a, a);
      check("settle_hold_b", mult_b, b);
      @(posedge clk); #1;
      n++;
    end
    check("latency", n, SETTLE + 1);
  endtask

  task automatic drain(input logic [255:0] a, input logic [255:0] b,
                       input logic [511:0] exp, input bit toggle);
    int          idx     = 0;
    int          guard   = 0;
    bit          stalled = 1'b0;
    logic [32:0] prev    = '0;
    while (idx < 16 && guard < 200) begin
      out_ready = toggle ? ~out_ready : 1'b1;
      check("send_in_ready", in_ready, 1'b0);
      check("send_hold_a", mult_a, a);
      check("send_hold_b", mult_b, b);
      if (stalled) check("stall_hold", {out_last, out_data}, prev);
      if (out_valid && out_ready) begin
        check($sformatf("w%0d", idx), {out_last, out_data}, {idx == 15, exp[idx*32 +: 32]});
        idx++;
        stalled = 1'b0;
      end else begin
        stalled = out_valid;
      end
      prev = {out_last, out_data};
      @(posedge clk); #1;
      guard++;
    end
    out_ready = 1'b1;
    check("drain_count", idx, 16);
    check("post_out_valid", out_valid, 1'b0);
    check("post_in_ready", in_ready, 1'b1);
    check("post_busy", busy, 1'b0);
  endtask

  task automatic run_op(input logic [255:0] a, input logic [255:0] b, input logic [511:0] exp,
                        input bit gaps, input bit toggle, input bit keep_valid,
                        input logic [31:0] next_word);
    load_op(a, b, gaps, keep_valid, next_word);
    wait_valid(a, b);
    drain(a, b, exp, toggle);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_mult_a", mult_a, 256'h0);
    check("rst_mult_b", mult_b, 256'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 32-bit all-ones squared: 0xFFFFFFFE_00000001
    run_op(256'hFFFFFFFF, 256'hFFFFFFFF, 512'hFFFFFFFE_00000001, 1'b0, 1'b0, 1'b0, 32'h0);

    // 256-bit all-ones squared: 2^512 - 2^257 + 1
    run_op({256{1'b1}}, {256{1'b1}},
           {{7{32'hFFFFFFFF}}, 32'hFFFFFFFE, {7{32'h0}}, 32'h1},
           1'b0, 1'b0, 1'b0, 32'h0);

    // 2^224 * 2^224 = 2^448: only word 14 set
    run_op({32'h1, 224'h0}, {32'h1, 224'h0}, {32'h0, 32'h1, 448'h0},
           1'b0, 1'b0, 1'b0, 32'h0);

    // Gapped input, toggling out_ready, in_valid held high through SETTLE/SEND
    run_op(256'h5829EC10, 256'h123BBBCF_00000000, 512'h064784F0_710590F0_00000000,
           1'b1, 1'b1, 1'b1, 32'hDEADBEEF);
    in_valid = 1'b0;

    // Reset in the middle of loading A
    for (int i = 0; i < 5; i++) send_word(32'hA5A50000 + 32'(i), 1'b0);
    check("partial_busy", busy, 1'b1);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_in_ready", in_ready, 1'b1);
    check("abort_mult_a", mult_a, 256'h0);
    check("abort_busy", busy, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(256'h3, 256'h5, 512'hF, 1'b0, 1'b0, 1'b0, 32'h0);

    // Back-to-back with in_valid never dropping between operations
    run_op(256'h10000, 256'h10000, 512'h1_00000000, 1'b0, 1'b0, 1'b1, 32'h7);
    run_op(256'h7, 256'h6, 512'h2A, 1'b0, 1'b0, 1'b0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
